// File: rtl/alu_seq_pkg.sv
// Shared types, widths and flag bit positions for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned FUNC_W    = 5;
  localparam int unsigned FLAGS_W   = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned OPCNT_W   = 16;

  localparam int unsigned FLAG_CARRY = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_NEG   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [TYPE_W-1:0]    op_type;
    logic [FUNC_W-1:0]    func;
  } alu_op_t;

  // Assemble the response flag nibble from the individual ALU flags.
  function automatic logic [FLAGS_W-1:0] pack_flags(input logic carry, input logic zero,
                                                    input logic ovf, input logic neg);
    logic [FLAGS_W-1:0] f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_ZERO]  = zero;
    f[FLAG_OVF]   = ovf;
    f[FLAG_NEG]   = neg;
    return f;
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter that times how long ALU inputs are held before capture.
module alu_settle_counter
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Saturates at zero; the sequencer leaves SETTLE on the zero cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through a combinational ALU: latch operands,
// hold them SETTLE_CYCLES, capture the result, then hand it off over a valid/ready port.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPERAND_W-1:0] req_a,
  input  logic [OPERAND_W-1:0] req_b,
  input  logic [TYPE_W-1:0]    req_type,
  input  logic [FUNC_W-1:0]    req_func,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  output logic [TYPE_W-1:0]    alu_type,
  output logic [FUNC_W-1:0]    alu_func,
  input  logic [OPERAND_W-1:0] alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_negative,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OPERAND_W-1:0] rsp_result,
  output logic [FLAGS_W-1:0]   rsp_flags,
  output logic [OPCNT_W-1:0]   op_count
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t  state;
  alu_op_t op_q;
  logic    accept_c;
  logic    settle_c;
  logic    cnt_zero_c;

  assign accept_c = (state == IDLE) && req_ready && req_valid;
  assign settle_c = (state == SETTLE);

  alu_settle_counter u_settle_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept_c),
    .load_value (SETTLE_LOAD),
    .dec        (settle_c),
    .zero_c     (cnt_zero_c)
  );

  // ALU drive comes straight from the operand register, so it only moves on acceptance.
  assign alu_a    = op_q.a;
  assign alu_b    = op_q.b;
  assign alu_type = op_q.op_type;
  assign alu_func = op_q.func;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      op_count   <= '0;
      rsp_valid  <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_q      <= '{a: req_a, b: req_b, op_type: req_type, func: req_func};
            req_ready <= 1'b0;
            state     <= SETTLE;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_zero_c) begin
            rsp_result <= alu_result;
            rsp_flags  <= pack_flags(alu_carry, alu_zero, alu_overflow, alu_negative);
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          // req_ready rises with the handshake so acceptance can happen on the next edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + OPCNT_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1, one with 4.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1;
  logic [31:0] req_a1, req_b1, alu_a1, alu_b1, alu_result1, rsp_result1;
  logic [1:0]  req_type1, alu_type1;
  logic [4:0]  req_func1, alu_func1;
  logic        alu_carry1, alu_zero1, alu_overflow1, alu_negative1;
  logic [3:0]  rsp_flags1;
  logic [15:0] op_count1;
  logic [32:0] sum1;

  logic        req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [31:0] req_a4, req_b4, alu_a4, alu_b4, alu_result4, rsp_result4;
  logic [1:0]  req_type4, alu_type4;
  logic [4:0]  req_func4, alu_func4;
  logic        alu_carry4, alu_zero4, alu_overflow4, alu_negative4;
  logic [3:0]  rsp_flags4;
  logic [15:0] op_count4;
  logic [32:0] sum4;

  int vectors;
  int miscompares;

  // ALU model: adder with carry, zero, signed overflow and sign flags.
  assign sum1          = {1'b0, alu_a1} + {1'b0, alu_b1};
  assign alu_result1   = sum1[31:0];
  assign alu_carry1    = sum1[32];
  assign alu_zero1     = (sum1[31:0] == 32'h0);
  assign alu_overflow1 = (alu_a1[31] == alu_b1[31]) && (sum1[31] != alu_a1[31]);
  assign alu_negative1 = sum1[31];

  assign sum4          = {1'b0, alu_a4} + {1'b0, alu_b4};
  assign alu_result4   = sum4[31:0];
  assign alu_carry4    = sum4[32];
  assign alu_zero4     = (sum4[31:0] == 32'h0);
  assign alu_overflow4 = (alu_a4[31] == alu_b4[31]) && (sum4[31] != alu_a4[31]);
  assign alu_negative4 = sum4[31];

  alu_op_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_type(req_type1), .req_func(req_func1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_type(alu_type1), .alu_func(alu_func1),
    .alu_result(alu_result1), .alu_carry(alu_carry1), .alu_zero(alu_zero1),
    .alu_overflow(alu_overflow1), .alu_negative(alu_negative1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1),
    .rsp_flags(rsp_flags1), .op_count(op_count1)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .req_type(req_type4), .req_func(req_func4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_type(alu_type4), .alu_func(alu_func4),
    .alu_result(alu_result4), .alu_carry(alu_carry4), .alu_zero(alu_zero4),
    .alu_overflow(alu_overflow4), .alu_negative(alu_negative4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_flags(rsp_flags4), .op_count(op_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete operation on the SETTLE_CYCLES=1 instance with rsp_ready already high.
  task automatic run_op1(input logic [31:0] a, input logic [31:0] b,
                         output logic vld_k1, output logic [31:0] res, output logic [3:0] flg,
                         output logic vld_k2, output logic rdy_k2, output logic [15:0] cnt);
    @(negedge clk);
    req_valid1 = 1'b1; req_a1 = a; req_b1 = b; rsp_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld_k1 = rsp_valid1; res = rsp_result1; flg = rsp_flags1;
    @(posedge clk);
    @(negedge clk);
    vld_k2 = rsp_valid1; rdy_k2 = req_ready1; cnt = op_count1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; req_type1 = '0; req_func1 = '0; rsp_ready1 = 1'b0;
    req_valid4 = 1'b0; req_a4 = '0; req_b4 = '0; req_type4 = '0; req_func4 = '0; rsp_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready1, rsp_valid1, alu_a1, alu_b1, alu_type1, alu_func1, rsp_result1, rsp_flags1, op_count1} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut1: got rdy=%b vld=%b a=%h res=%h flags=%b cnt=%h, expected all zero",
               req_ready1, rsp_valid1, alu_a1, rsp_result1, rsp_flags1, op_count1);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready1 !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %b expected 0", req_ready1); end
    @(negedge clk);
    vectors++;
    if (req_ready1 !== 1'b1 || req_ready4 !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready_rise: got %b/%b expected 1/1", req_ready1, req_ready4);
    end
  endtask

  task automatic test_basic();
    logic v1, v2, r2; logic [31:0] res; logic [3:0] flg; logic [15:0] cnt;
    req_type1 = 2'b10; req_func1 = 5'b00010;
    run_op1(32'd3, 32'd1, v1, res, flg, v2, r2, cnt);
    vectors++;
    if (v1 !== 1'b1) begin miscompares++; $display("FAIL basic_latency: rsp_valid got %b expected 1", v1); end
    vectors++;
    if (res !== 32'h4 || flg !== 4'b0000) begin
      miscompares++; $display("FAIL basic_result: got %h/%b expected 00000004/0000", res, flg);
    end
    vectors++;
    if (alu_type1 !== 2'b10 || alu_func1 !== 5'b00010) begin
      miscompares++; $display("FAIL basic_alu_ctl: got %b/%b expected 10/00010", alu_type1, alu_func1);
    end
    vectors++;
    if (v2 !== 1'b0 || r2 !== 1'b1 || cnt !== 16'd1) begin
      miscompares++; $display("FAIL basic_handshake: got vld=%b rdy=%b cnt=%0d expected 0 1 1", v2, r2, cnt);
    end
    vectors++;
    if (rsp_result1 !== 32'h4) begin miscompares++; $display("FAIL basic_hold: got %h expected 00000004", rsp_result1); end
  endtask

  task automatic test_flags();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] er [3];
    logic [3:0]  ef [3];
    logic v1, v2, r2; logic [31:0] res; logic [3:0] flg; logic [15:0] cnt;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'h1;         er[0] = 32'h0;         ef[0] = 4'b1100;
    av[1] = 32'h7FFF_FFFF; bv[1] = 32'h1;         er[1] = 32'h8000_0000; ef[1] = 4'b0011;
    av[2] = 32'h8000_0000; bv[2] = 32'h8000_0000; er[2] = 32'h0;         ef[2] = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      run_op1(av[i], bv[i], v1, res, flg, v2, r2, cnt);
      vectors++;
      if (v1 !== 1'b1 || res !== er[i] || flg !== ef[i]) begin
        miscompares++;
        $display("FAIL flags_%0d: got vld=%b res=%h flags=%b expected 1 %h %b", i, v1, res, flg, er[i], ef[i]);
      end
      vectors++;
      if (cnt !== 16'(i + 2)) begin miscompares++; $display("FAIL flags_cnt_%0d: got %0d expected %0d", i, cnt, i + 2); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid1 = 1'b1; req_a1 = 32'd10; req_b1 = 32'd20; rsp_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_a1 = 32'd100;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_valid1 !== 1'b1 || rsp_result1 !== 32'd30) begin
      miscompares++; $display("FAIL b2b_first: got vld=%b res=%h expected 1 0000001e", rsp_valid1, rsp_result1);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (alu_a1 !== 32'd10 || req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
      miscompares++; $display("FAIL b2b_no_turnaround: got a=%h rdy=%b vld=%b expected 0000000a 1 0", alu_a1, req_ready1, rsp_valid1);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (alu_a1 !== 32'd100 || req_ready1 !== 1'b0) begin
      miscompares++; $display("FAIL b2b_second_accept: got a=%h rdy=%b expected 00000064 0", alu_a1, req_ready1);
    end
    req_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rsp_valid1 !== 1'b1 || rsp_result1 !== 32'd120) begin
      miscompares++; $display("FAIL b2b_second_result: got vld=%b res=%h expected 1 00000078", rsp_valid1, rsp_result1);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (op_count1 !== 16'd6) begin miscompares++; $display("FAIL b2b_count: got %0d expected 6", op_count1); end
  endtask

  task automatic test_stall();
    logic exp_vld;
    @(negedge clk);
    req_valid4 = 1'b1; req_a4 = 32'h10; req_b4 = 32'h20; req_type4 = 2'b01; req_func4 = 5'd5; rsp_ready4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_a4 = 32'hDEAD; req_b4 = 32'hBEEF;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_vld = (i >= 4);
      vectors++;
      if (rsp_valid4 !== exp_vld || req_ready4 !== 1'b0 || alu_a4 !== 32'h10 || op_count4 !== 16'd0) begin
        miscompares++;
        $display("FAIL stall_k%0d: got vld=%b rdy=%b a=%h cnt=%0d expected %b 0 00000010 0",
                 i, rsp_valid4, req_ready4, alu_a4, op_count4, exp_vld);
      end
      if (i >= 4) begin
        vectors++;
        if (rsp_result4 !== 32'h30 || rsp_flags4 !== 4'b0000) begin
          miscompares++; $display("FAIL stall_result_k%0d: got %h/%b expected 00000030/0000", i, rsp_result4, rsp_flags4);
        end
      end
    end
    req_valid4 = 1'b0; rsp_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready4 = 1'b0;
    vectors++;
    if (op_count4 !== 16'd1 || rsp_valid4 !== 1'b0 || req_ready4 !== 1'b1 || alu_a4 !== 32'h10 || rsp_result4 !== 32'h30) begin
      miscompares++;
      $display("FAIL stall_handshake: got cnt=%0d vld=%b rdy=%b a=%h res=%h expected 1 0 1 00000010 00000030",
               op_count4, rsp_valid4, req_ready4, alu_a4, rsp_result4);
    end
  endtask

  task automatic test_reset_mid_settle();
    @(negedge clk);
    req_valid4 = 1'b1; req_a4 = 32'd5; req_b4 = 32'd6; rsp_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid4 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready4, rsp_valid4, alu_a4, alu_b4, alu_type4, alu_func4, rsp_result4, rsp_flags4, op_count4} !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got rdy=%b vld=%b a=%h b=%h res=%h cnt=%0d expected all zero",
               req_ready4, rsp_valid4, alu_a4, alu_b4, rsp_result4, op_count4);
    end
    vectors++;
    if (op_count1 !== 16'd0) begin miscompares++; $display("FAIL midreset_cnt1: got %0d expected 0", op_count1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready4 !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b expected 1", req_ready4); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid4 !== 1'b0 || op_count4 !== 16'd0) begin
        miscompares++; $display("FAIL midreset_quiet_%0d: got vld=%b cnt=%0d expected 0 0", i, rsp_valid4, op_count4);
      end
    end
  endtask

  task automatic test_wrap();
    logic v1, v2, r2; logic [31:0] res; logic [3:0] flg; logic [15:0] cnt;
    @(negedge clk);
    force u_dut1.op_count = 16'hFFFF;
    @(negedge clk);
    release u_dut1.op_count;
    run_op1(32'd1, 32'd2, v1, res, flg, v2, r2, cnt);
    vectors++;
    if (cnt !== 16'h0000 || res !== 32'd3) begin
      miscompares++; $display("FAIL wrap: got cnt=%h res=%h expected 0000 00000003", cnt, res);
    end
    run_op1(32'd0, 32'd0, v1, res, flg, v2, r2, cnt);
    vectors++;
    if (cnt !== 16'h0001 || res !== 32'd0 || flg !== 4'b0100) begin
      miscompares++; $display("FAIL wrap_next: got cnt=%h res=%h flags=%b expected 0001 00000000 0100", cnt, res, flg);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_stall();
    test_reset_mid_settle();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, legal range 1..15; cycles the ALU inputs are held before capture.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port req_valid  input  1  operation request present.
REQ-005 Port req_ready  output  1  sequencer can accept a request.
REQ-006 Port req_a, req_b  input  32 each  operands.
REQ-007 Port req_type  input  2  instruction type; req_func  input  5  function code.
REQ-008 Port alu_a, alu_b  output  32 each; alu_type  output  2; alu_func  output  5  drive to the combinational ALU.
REQ-009 Port alu_result  input  32; alu_carry, alu_zero, alu_overflow, alu_negative  input  1 each  ALU outputs.
REQ-010 Port rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-011 Port rsp_result  output  32; rsp_flags  output  4  {carry, zero, overflow, negative}, MSB first.
REQ-012 Port op_count  output  16  completed-operation counter.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, RESP.
REQ-014 IDLE: req_ready=1; req_valid=1 at an edge latches req_a/b/type/func into alu_* registers, loads the settle counter with SETTLE_CYCLES-1, and moves to SETTLE.
REQ-015 SETTLE: req_ready=0; counter decrements each edge; at the edge where the counter is 0, alu_result and the four flags are captured into rsp_result/rsp_flags and the FSM moves to RESP.
REQ-016 Latency: request accepted at edge k -> rsp_valid high from edge k+SETTLE_CYCLES.
REQ-017 RESP: rsp_valid=1, req_ready=0; rsp_result/rsp_flags stable until rsp_ready=1 at an edge, which returns to IDLE and increments op_count.
REQ-018 No overlapping operations; one request is outstanding at most; req_valid while busy is ignored, with no latching.
REQ-019 rsp_ready may be high before rsp_valid; the handshake completes on the first edge where both are high.
REQ-020 From IDLE, the earliest new acceptance is the edge after the RESP handshake; no same-edge turnaround.
REQ-021 alu_* outputs SHALL hold the last accepted operands until the next acceptance, and never change during SETTLE or RESP.
REQ-022 op_count wraps 0xFFFF -> 0x0000 without a flag.
REQ-023 rsp_result/rsp_flags SHALL hold their last captured values after a handshake.

Reset
REQ-024 rst_n=0 SHALL immediately force FSM=IDLE, settle counter=0, alu_a/b=0, alu_type=0, alu_func=0, rsp_result=0, rsp_flags=0, op_count=0, rsp_valid=0, req_ready=0.
REQ-025 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-026 Reset during SETTLE or RESP SHALL abort the operation with no response and no op_count increment.

Structure
REQ-027 Shared package alu_seq_pkg SHALL hold the state enum, the flag bit indices (CARRY=3, ZERO=2, OVF=1, NEG=0), and the operand, type, and function widths.
REQ-028 One sub-module alu_settle_counter, a 4-bit loadable down-counter with a zero flag, is natural; the FSM and registers stay in alu_op_sequencer.

Verification
REQ-029 The bench SHALL model the ALU as result=a+b, carry=33rd bit, zero=(result==0), overflow=signed overflow, negative=result[31].
REQ-030 a=3, b=1, type=2'b10, func=5'b00010, SETTLE_CYCLES=1, rsp_ready=1 -> rsp_valid one cycle after acceptance, rsp_result=0x00000004, rsp_flags=4'b0000, op_count=1.
REQ-031 a=0xFFFFFFFF, b=1 -> rsp_result=0, rsp_flags=4'b1100; a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_flags=4'b0011.
REQ-032 SETTLE_CYCLES=4, rsp_ready held low 5 cycles -> rsp_valid from k+4, result stable, req_ready=0 throughout, a second req_valid is not accepted, and op_count increments only on the handshake.
REQ-033 rst_n pulsed low mid-SETTLE -> all outputs zero asynchronously, no rsp_valid, op_count=0, req_ready=1 the cycle after release.
REQ-034 Preload op_count to 0xFFFF via 65535 operations, or force it, then complete one operation -> op_count=0x0000.
